// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// State encodings and the default exception vector live here.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPend  = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam logic [31:0] ExcVectorDefault = 32'hBFC0_0380;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc set,
// sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble decode plus registered exception/eret flush sequencer.
// Define PIPE_CTRL_PERF_EN to build the stall and flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned        STAGES     = 6,
  parameter int unsigned        EXC_STAGE  = 4,
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR = ADDR_W'(ExcVectorDefault),
  parameter int unsigned        CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_all,
  input  logic [STAGES-1:0] stall_req,
  input  logic              exc_valid,
  input  logic              eret_valid,
  input  logic [ADDR_W-1:0] epc_in,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic [STAGES-1:0] flush,
  output logic              flush_pc_valid,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e            state_q;
  logic [STAGES-1:0] flush_q;
  logic              flush_pc_valid_q;
  logic [ADDR_W-1:0] flush_pc_q;
  logic [STAGES-1:0] flush_mask;
  logic [STAGES-1:0] req;

  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      flush_mask[i] = (i <= EXC_STAGE);
    end
  end

  // Requests come from instructions being flushed, so ignore them in FLUSH.
  assign req = (state_q == StFlush) ? '0 : stall_req;

  // Stage i holds whenever it or any later stage requests a hold.
  always_comb begin
    stall = '0;
    for (int i = 0; i < STAGES; i++) begin
      stall[i] = |(req >> i);
    end
    if (stall_all) begin
      stall = '1;
    end
  end

  assign bubble = stall & ~(stall >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      flush_q          <= '0;
      flush_pc_valid_q <= 1'b0;
      flush_pc_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (exc_valid || eret_valid) begin
            flush_pc_q <= exc_valid ? EXC_VECTOR : epc_in;
            if (stall_all) begin
              state_q <= StPend;
            end else begin
              state_q          <= StFlush;
              flush_q          <= flush_mask;
              flush_pc_valid_q <= 1'b1;
            end
          end
        end
        StPend: begin
          if (!stall_all) begin
            state_q          <= StFlush;
            flush_q          <= flush_mask;
            flush_pc_valid_q <= 1'b1;
          end
        end
        StFlush: begin
          if (!stall_all) begin
            state_q          <= StIdle;
            flush_q          <= '0;
            flush_pc_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= StIdle;
          flush_q          <= '0;
          flush_pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush          = flush_q;
  assign flush_pc_valid = flush_pc_valid_q;
  assign flush_pc       = flush_pc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = |stall;
  // A flush is consumed on the edge that leaves FLUSH.
  assign flush_inc = (state_q == StFlush) && !stall_all;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
